// File: rtl/td4_pkg.sv
// Shared TD4 definitions: clock-mode encodings used by the clock generator,
// the CPU-side decoder and the top-level pin mapping.
package td4_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_SLOW   = 2'b01,
    MODE_FAST   = 2'b10,
    MODE_FULL   = 2'b11
  } clk_mode_t;

  function automatic int unsigned max_div(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/td4_clkgen_if.sv
// Board-side bundle of the TD4 clock generator: mode selector and raw step
// button in, CPU step strobe and issued-step counter out.
interface td4_clkgen_if;

  logic [1:0] mode;
  logic       step_btn;
  logic       cpu_en;
  logic [7:0] step_count;

  modport master (
    output mode,
    output step_btn,
    input  cpu_en,
    input  step_count
  );

  modport slave (
    input  mode,
    input  step_btn,
    output cpu_en,
    output step_count
  );

endinterface

// File: rtl/td4_debounce.sv
// Push-button front end: two-flop synchronizer, optional debounce filter
// (CLKGEN_DEBOUNCE_EN) and a one-cycle pulse on each accepted 0->1 change.
module td4_debounce #(
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  if (DEB_CYCLES < 32'd1) begin : g_bad_deb
    $error("td4_debounce: DEB_CYCLES must be at least 1");
  end

  logic s1_q;
  logic s2_q;
  logic deb_q;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

`ifdef CLKGEN_DEBOUNCE_EN
  localparam int unsigned CW = (DEB_CYCLES > 32'd1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          deb_d;
  logic          prev_q;

  // A level change is accepted only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Filter state and the delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q  <= 1'b0;
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      prev_q <= deb_q;
    end
  end

  assign level = deb_q;
  assign rise  = deb_q & ~prev_q;
`else
  // Unfiltered: deb tracks s2 one cycle late, so the edge is seen while s2 leads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= 1'b0;
    end else begin
      deb_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~deb_q;
`endif

endmodule

// File: rtl/td4_clkgen.sv
// TD4 CPU clock-enable generator: manual step, slow/fast divided and full-speed
// cpu_en strobe plus issued-step counter. Button debounce via CLKGEN_DEBOUNCE_EN.
module td4_clkgen
  import td4_pkg::*;
#(
  parameter int unsigned DIV_SLOW   = 50_000_000,
  parameter int unsigned DIV_FAST   = 5_000_000,
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic         clk,
  input  logic         rst,
  td4_clkgen_if.slave  bus
);

  if ((DIV_SLOW < 32'd2) || (DIV_FAST < 32'd2)) begin : g_bad_div
    $error("td4_clkgen: DIV_SLOW and DIV_FAST must be at least 2");
  end

  localparam int unsigned DW = $clog2(max_div(DIV_SLOW, DIV_FAST));
  localparam logic [DW-1:0] SLOW_LAST = DW'(DIV_SLOW - 32'd1);
  localparam logic [DW-1:0] FAST_LAST = DW'(DIV_FAST - 32'd1);

  clk_mode_t     mode_s;
  clk_mode_t     mode_q;
  logic          mode_chg_s;
  logic [DW-1:0] div_last_s;
  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;
  logic          cpu_en_q;
  logic          cpu_en_d;
  logic [7:0]    step_count_q;
  logic [7:0]    step_count_d;
  logic          deb_level_s;
  logic          deb_rise_s;
  logic          press_s;

  td4_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.step_btn),
    .level (deb_level_s),
    .rise  (deb_rise_s)
  );

  assign press_s    = deb_rise_s & deb_level_s;
  assign mode_s     = clk_mode_t'(bus.mode);
  assign mode_chg_s = (mode_s != mode_q);
  assign div_last_s = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

  // Strobe/divider next state; a mode change restarts the count and emits nothing.
  always_comb begin
    div_cnt_d = '0;
    cpu_en_d  = 1'b0;
    if (mode_chg_s) begin
      div_cnt_d = '0;
      cpu_en_d  = 1'b0;
    end else begin
      case (mode_q)
        MODE_MANUAL: cpu_en_d = press_s;
        MODE_SLOW, MODE_FAST: begin
          if (div_cnt_q == div_last_s) begin
            cpu_en_d  = 1'b1;
            div_cnt_d = '0;
          end else begin
            cpu_en_d  = 1'b0;
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
        MODE_FULL:   cpu_en_d = 1'b1;
        default:     cpu_en_d = 1'b0;
      endcase
    end
  end

  assign step_count_d = step_count_q + {7'd0, cpu_en_q};

  // Mode register, divider, strobe and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_MANUAL;
      div_cnt_q    <= '0;
      cpu_en_q     <= 1'b0;
      step_count_q <= 8'd0;
    end else begin
      mode_q       <= mode_s;
      div_cnt_q    <= div_cnt_d;
      cpu_en_q     <= cpu_en_d;
      step_count_q <= step_count_d;
    end
  end

  assign bus.cpu_en     = cpu_en_q;
  assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_td4_clkgen.sv
// Directed bench for td4_clkgen (DIV_SLOW=5, DIV_FAST=3, DEB_CYCLES=4); expected
// manual latencies follow whether CLKGEN_DEBOUNCE_EN is defined.
module tb_td4_clkgen;
  import td4_pkg::*;

`ifdef CLKGEN_DEBOUNCE_EN
  localparam int MAN_LAT       = 7;
  localparam int BOUNCE_PULSES = 1;
  localparam int BOUNCE_LAST   = 23;
`else
  localparam int MAN_LAT       = 3;
  localparam int BOUNCE_PULSES = 5;
  localparam int BOUNCE_LAST   = 19;
`endif
  localparam int DRAIN = 12;

  typedef struct {
    logic [1:0] mode;
    logic       btn;
    int         cycles;
    int         first;
    int         pulses;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  td4_clkgen_if bus();

  td4_clkgen #(
    .DIV_SLOW   (5),
    .DIV_FAST   (3),
    .DEB_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int model_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one vector then DRAIN idle MANUAL cycles; pulses are counted throughout.
  task automatic run_vec(input logic [1:0] m, input logic b, input int cycles,
                         output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int k = 0; k < cycles + DRAIN; k++) begin
      if (bus.cpu_en === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
      bus.mode     = (k < cycles) ? m : MODE_MANUAL;
      bus.step_btn = (k < cycles) ? b : 1'b0;
      tick();
    end
  endtask

  vec_t vecs[6];
  int   pulses, first, last, wraps, early;
  logic [7:0] prev_cnt;
  logic en_hist[25];

  initial begin
    vecs[0] = '{MODE_MANUAL, 1'b0, 10, -1,      0};
    vecs[1] = '{MODE_MANUAL, 1'b1, 20, MAN_LAT, 1};
    vecs[2] = '{MODE_SLOW,   1'b0, 22, 6,       4};
    vecs[3] = '{MODE_FAST,   1'b0, 12, 4,       3};
    vecs[4] = '{MODE_SLOW,   1'b1, 11, 6,       2};
    vecs[5] = '{MODE_FULL,   1'b0, 8,  2,       7};

    // Reset with FULL selected and the button held.
    rst          = 1'b1;
    bus.mode     = MODE_FULL;
    bus.step_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst%0d_cpu_en", i), int'(bus.cpu_en), 0);
      check($sformatf("rst%0d_step_count", i), int'(bus.step_count), 0);
    end
    rst = 1'b0;
    tick();
    check("rst_release_cpu_en", int'(bus.cpu_en), 0);
    tick();
    check("rst_full_first_cpu_en", int'(bus.cpu_en), 1);
    bus.mode     = MODE_MANUAL;
    bus.step_btn = 1'b0;
    repeat (DRAIN) tick();
    model_cnt = 1;
    check("rst_step_count", int'(bus.step_count), model_cnt);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i].mode, vecs[i].btn, vecs[i].cycles, pulses, first);
      model_cnt = (model_cnt + vecs[i].pulses) % 256;
      check($sformatf("vec%0d_first", i), first, vecs[i].first);
      check($sformatf("vec%0d_pulses", i), pulses, vecs[i].pulses);
      check($sformatf("vec%0d_step_count", i), int'(bus.step_count), model_cnt);
    end

    // Bounce: 2-high/2-low toggling for 16 cycles, then held high for 10.
    pulses = 0;
    last   = -1;
    for (int k = 0; k < 26 + DRAIN; k++) begin
      if (bus.cpu_en === 1'b1) begin
        pulses++;
        last = k;
      end
      bus.mode     = MODE_MANUAL;
      bus.step_btn = (k < 16) ? (((k >> 1) & 1) == 0) : (k < 26);
      tick();
    end
    model_cnt = (model_cnt + BOUNCE_PULSES) % 256;
    check("bounce_pulses", pulses, BOUNCE_PULSES);
    check("bounce_last_pulse", last, BOUNCE_LAST);

    // Mid-count switch SLOW->FAST while div_cnt is 3.
    for (int k = 0; k < 25; k++) begin
      en_hist[k]   = bus.cpu_en;
      bus.mode     = (k < 4) ? MODE_SLOW : ((k < 13) ? MODE_FAST : MODE_MANUAL);
      bus.step_btn = 1'b0;
      tick();
    end
    early = 0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      if (en_hist[k] === 1'b1) pulses++;
      if ((k < 8) && (en_hist[k] === 1'b1)) early++;
    end
    model_cnt = (model_cnt + 2) % 256;
    check("mid_no_partial_strobe", early, 0);
    check("mid_first_fast_strobe", int'(en_hist[8]), 1);
    check("mid_second_fast_strobe", int'(en_hist[11]), 1);
    check("mid_pulses", pulses, 2);

    // FULL for 260 cycles: constant strobe, counter wraps once.
    pulses   = 0;
    first    = -1;
    last     = -1;
    wraps    = 0;
    prev_cnt = bus.step_count;
    for (int k = 0; k < 260 + DRAIN; k++) begin
      if (bus.cpu_en === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
        last = k;
      end
      if ((bus.step_count == 8'd0) && (prev_cnt == 8'd255)) wraps++;
      prev_cnt     = bus.step_count;
      bus.mode     = (k < 260) ? MODE_FULL : MODE_MANUAL;
      bus.step_btn = 1'b0;
      tick();
    end
    model_cnt = (model_cnt + 259) % 256;
    check("full_first", first, 2);
    check("full_last", last, 260);
    check("full_pulses", pulses, 259);
    check("full_wraps", wraps, 1);
    check("full_step_count", int'(bus.step_count), model_cnt);

    // Reset in the middle of a held press: it must re-qualify from scratch.
    pulses = 0;
    first  = -1;
    for (int k = 0; k < 23 + DRAIN; k++) begin
      if (k == 3) begin
        check("rstmid_step_count", int'(bus.step_count), 0);
        check("rstmid_cpu_en", int'(bus.cpu_en), 0);
      end
      if (bus.cpu_en === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
      rst          = (k == 2);
      bus.mode     = MODE_MANUAL;
      bus.step_btn = (k < 23);
      tick();
    end
    model_cnt = 1;
    check("rstmid_pulses", pulses, 1);
    check("rstmid_first", first, 3 + MAN_LAT);
    check("rstmid_final_step_count", int'(bus.step_count), model_cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/td4_clkgen.md
# td4_clkgen

CPU clock-enable generator that sits directly upstream of the TD4 CPU core. Turns the board clock plus a mode selector and a raw manual-step push-button into a single-cycle `cpu_en` strobe that gates every CPU state update (PC, A, B, output port, carry). Provides manual single-step, slow, fast and full-speed execution, the classic TD4 clock-selection options.

## Interface
- `DIV_SLOW`, default 50_000_000: board cycles per CPU step in SLOW mode, ≥2.
- `DIV_FAST`, default 5_000_000: board cycles per CPU step in FAST mode, ≥2.
- `DEB_CYCLES`, default 500_000: consecutive stable synchronized samples required to accept a button level change, ≥1.
- `clk`  in  1  board clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset. Clock is `clk`; reset is synchronous and active-high.
- `mode`  in  2  00 MANUAL, 01 SLOW, 10 FAST, 11 FULL. Quasi-static; sampled every cycle.
- `step_btn`  in  1  raw asynchronous push-button, active-high.
- `cpu_en`  out  1  registered CPU step strobe.
- `step_count`  out  8  registered count of `cpu_en` pulses issued; wraps 255→0.

## Operation
- Synchronizer: `step_btn` passes through two flops (s1, s2) before any use.
- Debounce with `CLKGEN_DEBOUNCE_EN`: `deb_cnt` increments while s2 ≠ `deb`. When s2 ≠ `deb` and `deb_cnt` == DEB_CYCLES-1: `deb` <= s2, `deb_cnt` <= 0. When s2 == `deb`: `deb_cnt` <= 0. Any glitch shorter than DEB_CYCLES samples is discarded.
- Press detect: `press` is asserted for one cycle when `deb` goes 0→1. Release is ignored.
- Mode register: `mode_q` <= `mode` each cycle. FSM state = `mode_q`. If `mode` ≠ `mode_q`, `div_cnt` <= 0 in that cycle.
- MANUAL: `cpu_en` <= `press`. Exactly one strobe per accepted press. `div_cnt` is held at 0.
- SLOW/FAST: `div_cnt` counts 0..DIV-1 and wraps. `cpu_en` <= 1 on the cycle `div_cnt` == DIV-1, else 0. Presses are ignored.
- FULL: `cpu_en` <= 1 every cycle. Presses are ignored.
- `step_count` increments in the cycle after each `cpu_en` high cycle, i.e. it reflects strobes already issued.
- `div_cnt` width is $clog2(max(DIV_SLOW, DIV_FAST)). Counter compare uses the DIV of the current `mode_q`.

## Timing
- Reset values: `cpu_en`=0, `step_count`=0, s1=s2=0, `deb`=0, `deb_cnt`=0, `div_cnt`=0, `mode_q`=00 (MANUAL).
- Reset mid-operation: all of the above are cleared on the next edge. A press in progress must be re-qualified from scratch after reset releases.
- Manual latency (debounce on): `step_btn` high and stable from cycle 0 gives first `cpu_en` high in cycle DEB_CYCLES+3 (2 sync + DEB_CYCLES + 1 register), width exactly 1 cycle.
- Manual latency (debounce off): `cpu_en` high in cycle 3 after a 0→1 on `step_btn`, width 1.
- SLOW/FAST: the first strobe comes exactly DIV cycles after the edge at which `mode_q` takes the new value. The period is then exactly DIV cycles.
- Mode change while `div_cnt` is mid-count: the count restarts and no partial-period strobe is emitted.
- A press that completes debounce in the same cycle that `mode_q` leaves MANUAL is dropped.

## Configuration
- `CLKGEN_DEBOUNCE_EN` defined: debounce counter present, behaving as described above.
- `CLKGEN_DEBOUNCE_EN` undefined: `deb` <= s2 directly, no counter, and DEB_CYCLES is ignored. Used for fast simulation; bounce is not filtered.

## Structure
- The shared package `td4_pkg` holds the mode encodings as the 2-bit typedef `clk_mode_t` with constants MODE_MANUAL, MODE_SLOW, MODE_FAST, MODE_FULL. The CPU-side decoder and top-level pin mapping import the same package.
- One sub-module, `td4_debounce`, covers synchronizer + debounce + rising-edge pulse. It takes parameter DEB_CYCLES and ports `clk`, `rst`, `din`, `level`, `rise`. The macro applies inside it.
- `td4_clkgen` holds the mode register, divider, strobe and step counter.

## Test plan
- Reset: assert `rst` 3 cycles with `mode`=11 and the button pressed. Required: `cpu_en`=0, `step_count`=0 through reset; the first `cpu_en` appears only after `mode_q` samples 11.
- Manual step: DEB_CYCLES=4, `mode`=00; hold the button for 20 cycles, then release. Required: exactly one `cpu_en` pulse in cycle 7, and `step_count`=1.
- Bounce: DEB_CYCLES=4; toggle the button 1/0 every 2 cycles for 16 cycles, then hold it high for 10 cycles. Required: exactly one pulse, after the stable high, and none during toggling.
- Divider: DIV_SLOW=5, `mode`=01 for 22 cycles. Required: `cpu_en` high in cycles 6, 11, 16, 21 relative to the mode change, and `step_count`=4.
- Mid-count switch: DIV_SLOW=5, DIV_FAST=3. Switch 01→10 when `div_cnt`=3. Required: no strobe at the old boundary; the next strobe comes 3 cycles after `mode_q` updates.
- FULL plus wrap: `mode`=11 for 260 cycles. Required: `cpu_en` is constantly 1, and `step_count` wraps through 0 once.
